// File: rtl/ring_counter_pkg.sv
// Shared constants and helpers for the one-hot ring counter.
// Vectors are handled at MAX_WIDTH and truncated by the caller to the ring length.
package ring_counter_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int MAX_WIDTH     = 64;

  function automatic logic [MAX_WIDTH-1:0] onehot_init(input int width, input int pos);
    logic [MAX_WIDTH-1:0] v;
    v = '0;
    if (pos >= 0 && pos < width && pos < MAX_WIDTH) begin
      v = {{(MAX_WIDTH-1){1'b0}}, 1'b1} << pos;
    end
    return v;
  endfunction

  function automatic logic is_onehot(input logic [MAX_WIDTH-1:0] vec);
    int cnt;
    cnt = 0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      cnt += int'(vec[i]);
    end
    return (cnt == 1);
  endfunction

endpackage

// File: rtl/ring_counter_4_ring_stage.sv
// One bit of the ring: a DFF with a synchronous active-low reset that loads
// a per-bit reset value, plus its complemented output.
module ring_stage (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  input  logic i_rst_val,
  output logic o_q,
  output logic o_qbar
);

  logic r_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_q <= i_rst_val;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_q    = r_q;
  assign o_qbar = ~r_q;

endmodule

// File: rtl/ring_counter_4.sv
// Free-running one-hot ring counter with true and complemented outputs.
// Optional macro RING_SELF_CORRECT_EN reloads the init pattern on any non-one-hot state.
module ring_counter_4
  import ring_counter_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int INIT_POS = 0,
  parameter bit DIR_LEFT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
);

  localparam logic [WIDTH-1:0] INIT_VEC = WIDTH'(onehot_init(WIDTH, INIT_POS));

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_qbar;
  logic [WIDTH-1:0] w_rot;
  logic [WIDTH-1:0] w_next;

  // The wrap bit closes the ring: MSB feeds LSB when rotating left, LSB feeds MSB when right.
  generate
    if (DIR_LEFT) begin : g_left
      assign w_rot = {w_q[WIDTH-2:0], w_q[WIDTH-1]};
    end else begin : g_right
      assign w_rot = {w_q[0], w_q[WIDTH-1:1]};
    end
  endgenerate

`ifdef RING_SELF_CORRECT_EN
  logic [MAX_WIDTH-1:0] w_q_ext;
  assign w_q_ext = MAX_WIDTH'(w_q);
  assign w_next  = is_onehot(w_q_ext) ? w_rot : INIT_VEC;
`else
  assign w_next  = w_rot;
`endif

  generate
    for (genvar g = 0; g < WIDTH; g++) begin : g_stage
      ring_stage u_stage (
        .clk       (clk),
        .reset     (reset),
        .i_d       (w_next[g]),
        .i_rst_val (INIT_VEC[g]),
        .o_q       (w_q[g]),
        .o_qbar    (w_qbar[g])
      );
    end
  endgenerate

  assign q    = w_q;
  assign qbar = w_qbar;

endmodule

// File: tb/tb_ring_counter_4.sv
// Bench for ring_counter_4: four configurations compared each cycle against a
// position-based reference model, with directed sequences followed by random resets.
module tb_ring_counter_4;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  logic [3:0] q0, qb0, q1, qb1;
  logic [7:0] q2, qb2;
  logic [4:0] q3, qb3;

  ring_counter_4 #(.WIDTH(4), .INIT_POS(0), .DIR_LEFT(1'b1)) dut0 (
    .clk(clk), .reset(reset), .q(q0), .qbar(qb0));
  ring_counter_4 #(.WIDTH(4), .INIT_POS(0), .DIR_LEFT(1'b0)) dut1 (
    .clk(clk), .reset(reset), .q(q1), .qbar(qb1));
  ring_counter_4 #(.WIDTH(8), .INIT_POS(3), .DIR_LEFT(1'b1)) dut2 (
    .clk(clk), .reset(reset), .q(q2), .qbar(qb2));
  ring_counter_4 #(.WIDTH(5), .INIT_POS(4), .DIR_LEFT(1'b0)) dut3 (
    .clk(clk), .reset(reset), .q(q3), .qbar(qb3));

  int wid[N]      = '{4, 4, 8, 5};
  int ini[N]      = '{0, 0, 3, 4};
  bit dir_left[N] = '{1'b1, 1'b0, 1'b1, 1'b0};

  int pos[N];
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Reference: track where the single 1 sits and move it with modular arithmetic.
  task automatic model_edge(input bit rst_n);
    logic [7:0] mask;
    logic [7:0] e;
    for (int i = 0; i < N; i++) begin
      if (!rst_n) pos[i] = ini[i];
      else if (dir_left[i]) pos[i] = (pos[i] + 1) % wid[i];
      else pos[i] = (pos[i] + wid[i] - 1) % wid[i];
      mask = 8'((1 << wid[i]) - 1);
      e    = 8'(1 << pos[i]);
      exp_q.push_back(e);
      exp_q.push_back(~e & mask);
    end
  endtask

  task automatic step(input bit rst_n, input string tag);
    logic [7:0] got[2*N];
    reset = rst_n;
    @(posedge clk);
    model_edge(rst_n);
    @(negedge clk);
    got[0] = 8'(q0); got[1] = 8'(qb0);
    got[2] = 8'(q1); got[3] = 8'(qb1);
    got[4] = q2;     got[5] = qb2;
    got[6] = 8'(q3); got[7] = 8'(qb3);
    for (int k = 0; k < 2*N; k++) begin
      check($sformatf("%s/d%0d/%s", tag, k/2, (k % 2 == 0) ? "q" : "qbar"),
            got[k], exp_q.pop_front());
    end
  endtask

  logic [3:0] seq_left[8]  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001,
                               4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] seq_right[4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};

  initial begin
    reset = 1'b0;
    @(negedge clk);

    step(1'b0, "reset");
    check("reset_q0", 8'(q0), 8'b0000_0001);
    check("reset_qb0", 8'(qb0), 8'b0000_1110);
    check("reset_q2", q2, 8'b0000_1000);

    for (int i = 0; i < 8; i++) begin
      step(1'b1, "run");
      check($sformatf("seq_left[%0d]", i), 8'(q0), 8'(seq_left[i]));
      if (i < 4) check($sformatf("seq_right[%0d]", i), 8'(q1), 8'(seq_right[i]));
    end
    check("w8_period", q2, 8'b0000_1000);

    step(1'b1, "pre_mid");
    step(1'b1, "pre_mid");
    check("mid_before", 8'(q0), 8'b0000_0100);
    step(1'b0, "mid_reset");
    check("mid_reset_q0", 8'(q0), 8'b0000_0001);
    step(1'b1, "resume");
    check("resume_q0", 8'(q0), 8'b0000_0010);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 7) != 0), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
